// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared op/state encodings and 7-segment patterns for seq_alu_seg
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_SLT = 3'b110,
      OP_NEG = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_DONE
   } state_t;

   localparam logic [7:0] NUM_0 = 8'h3F;
   localparam logic [7:0] NUM_1 = 8'h06;
   localparam logic [7:0] NUM_2 = 8'h5B;
   localparam logic [7:0] NUM_3 = 8'h4F;
   localparam logic [7:0] NUM_4 = 8'h66;
   localparam logic [7:0] NUM_5 = 8'h6D;
   localparam logic [7:0] NUM_6 = 8'h7D;
   localparam logic [7:0] NUM_7 = 8'h07;
   localparam logic [7:0] NUM_8 = 8'h7F;
   localparam logic [7:0] NUM_9 = 8'h6F;
   localparam logic [7:0] DOT   = 8'h80;
   localparam logic [7:0] DASH  = 8'h40;

   function automatic logic [7:0] num_seg(input logic [3:0] d);
      case (d)
         4'd0:    return NUM_0;
         4'd1:    return NUM_1;
         4'd2:    return NUM_2;
         4'd3:    return NUM_3;
         4'd4:    return NUM_4;
         4'd5:    return NUM_5;
         4'd6:    return NUM_6;
         4'd7:    return NUM_7;
         4'd8:    return NUM_8;
         4'd9:    return NUM_9;
         default: return DASH;
      endcase
   endfunction

endpackage

// File: rtl/seq_alu_seg_if.sv
// rtl/seq_alu_seg_if.sv - request/result bundle between switch inputs and the ALU
interface seq_alu_seg_if #(
   parameter int NBITS_OPERAND = 4,
   parameter int NBITS_RESULT  = 2*NBITS_OPERAND
);
   logic                     start;
   logic [2:0]               op;
   logic [NBITS_OPERAND-1:0] a;
   logic [NBITS_OPERAND-1:0] b;
   logic                     busy;
   logic                     done;
   logic [NBITS_RESULT-1:0]  result;
   logic                     overflow;
   logic                     zero;
   logic [7:0]               seg;

   modport master (output start, op, a, b,
                   input  busy, done, result, overflow, zero, seg);
   modport slave  (input  start, op, a, b,
                   output busy, done, result, overflow, zero, seg);
endinterface

// File: rtl/seq_alu_seg_dec.sv
// rtl/seq_alu_seg_dec.sv - signed value to 7-segment pattern, DOT marks a negative digit
module seg7_signed_decoder
   import seq_alu_pkg::*;
#(
   parameter int NBITS_RESULT = 8
) (
   input  logic [NBITS_RESULT-1:0] value,
   output logic [7:0]              seg
);
   logic [NBITS_RESULT-1:0] mag;

   always_comb begin
      mag = value[NBITS_RESULT-1] ? ('0 - value) : value;
      seg = DASH;
      if (mag <= NBITS_RESULT'(9)) begin
         seg = num_seg(mag[3:0]) | (value[NBITS_RESULT-1] ? DOT : 8'h00);
      end
   end
endmodule

// File: rtl/seq_alu_seg.sv
// rtl/seq_alu_seg.sv - registered signed ALU with start/done handshake and 7-segment output
module seq_alu_seg
   import seq_alu_pkg::*;
#(
   parameter int NBITS_OPERAND = 4,
   parameter int NBITS_RESULT  = 2*NBITS_OPERAND,
   parameter int NBITS_CNT     = $clog2(NBITS_OPERAND+1)
) (
   input logic         clk_2,
   input logic         reset,
   seq_alu_seg_if.slave bus
);
   localparam int N  = NBITS_OPERAND;
   localparam int NR = NBITS_RESULT;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic           sign_q, sign_d;
   logic [NR-1:0]  acc_q, acc_d, mcand_q, mcand_d;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [NBITS_CNT-1:0] cnt_q, cnt_d;
   logic [NR-1:0]  result_q, result_d;
   logic           ovf_q, ovf_d, zero_q, zero_d;
   logic [7:0]     seg_q, seg_d;

   logic [NR-1:0]  a_ext, b_ext, exec_res, acc_step, prod, wr_val;
   logic [N-1:0]   lres, abs_a, abs_b;
   logic [N:0]     hi_bits;
   logic           exec_ovf;
   logic [7:0]     seg_val;

   // Result datapath: single-cycle ops and the final multiplier step
   always_comb begin
      a_ext    = {{(NR-N){a_q[N-1]}}, a_q};
      b_ext    = {{(NR-N){b_q[N-1]}}, b_q};
      lres     = '0;
      exec_res = '0;
      case (op_q)
         OP_ADD: exec_res = a_ext + b_ext;
         OP_SUB: exec_res = a_ext - b_ext;
         OP_AND: begin lres = a_q & b_q; exec_res = {{(NR-N){lres[N-1]}}, lres}; end
         OP_OR:  begin lres = a_q | b_q; exec_res = {{(NR-N){lres[N-1]}}, lres}; end
         OP_XOR: begin lres = a_q ^ b_q; exec_res = {{(NR-N){lres[N-1]}}, lres}; end
         OP_SLT: exec_res = {{(NR-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_NEG: exec_res = '0 - a_ext;
         default: exec_res = '0;
      endcase
      hi_bits  = exec_res[NR-1:N-1];
      exec_ovf = (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_NEG) &&
                 (|hi_bits) && !(&hi_bits);
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      prod     = sign_q ? ('0 - acc_step) : acc_step;
      wr_val   = (state_q == ST_MUL) ? prod : exec_res;
   end

   seg7_signed_decoder #(.NBITS_RESULT(NR)) u_dec (
      .value (wr_val),
      .seg   (seg_val)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      seg_d    = seg_q;
      abs_a    = bus.a[N-1] ? ('0 - bus.a) : bus.a;
      abs_b    = bus.b[N-1] ? ('0 - bus.b) : bus.b;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               op_d     = op_t'(bus.op);
               a_d      = bus.a;
               b_d      = bus.b;
               sign_d   = bus.a[N-1] ^ bus.b[N-1];
               acc_d    = '0;
               mcand_d  = {{(NR-N){1'b0}}, abs_a};
               mplier_d = abs_b;
               cnt_d    = '0;
               state_d  = (op_t'(bus.op) == OP_MUL) ? ST_MUL : ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = wr_val;
            ovf_d    = exec_ovf;
            zero_d   = (wr_val == '0);
            seg_d    = seg_val;
            state_d  = ST_DONE;
         end
         ST_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + NBITS_CNT'(1);
            if (cnt_q == NBITS_CNT'(N-1)) begin
               result_d = wr_val;
               ovf_d    = 1'b0;
               zero_d   = (wr_val == '0);
               seg_d    = seg_val;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
         seg_q    <= NUM_0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         seg_q    <= seg_d;
      end
   end

   assign bus.busy     = (state_q == ST_EXEC) || (state_q == ST_MUL);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.result   = result_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
   assign bus.seg      = seg_q;
endmodule

// File: tb/tb_seq_alu_seg.sv
// tb/tb_seq_alu_seg.sv - randomized and directed bench for seq_alu_seg against an integer model
module tb_seq_alu_seg;
   localparam int N  = 4;
   localparam int NR = 2*N;

   logic clk_2 = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   seq_alu_seg_if #(.NBITS_OPERAND(N), .NBITS_RESULT(NR)) bus ();

   seq_alu_seg #(.NBITS_OPERAND(N)) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk_2 = ~clk_2;

   logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_ref(input int r);
      if (r >= 0 && r <= 9)  return seg_tbl[r];
      if (r < 0 && r >= -9)  return seg_tbl[-r] | 8'h80;
      return 8'h40;
   endfunction

   function automatic void model(input int opc, input int av, input int bv,
                                 output int r, output bit ovf);
      case (opc)
         0: r = av + bv;
         1: r = av - bv;
         2: r = av & bv;
         3: r = av | bv;
         4: r = av ^ bv;
         5: r = av * bv;
         6: r = (av < bv) ? 1 : 0;
         default: r = -av;
      endcase
      ovf = (opc == 0 || opc == 1 || opc == 7) &&
            (r < -(1 << (N-1)) || r > (1 << (N-1)) - 1);
   endfunction

   task automatic wait_done(inout int lat);
      while (!bus.done && lat < 20) begin
         @(posedge clk_2); #1;
         lat++;
      end
      check("done_timeout", {31'b0, lat < 20}, 32'd1);
   endtask

   task automatic check_outputs(input string tag, input int r, input bit ovf);
      check({tag, "_result"}, {24'b0, bus.result}, r & ((1 << NR) - 1));
      check({tag, "_ovf"},    {31'b0, bus.overflow}, {31'b0, ovf});
      check({tag, "_zero"},   {31'b0, bus.zero}, (r == 0) ? 32'd1 : 32'd0);
      check({tag, "_seg"},    {24'b0, bus.seg}, {24'b0, seg_ref(r)});
   endtask

   task automatic drive(input int opc, input int av, input int bv);
      bus.op = 3'(opc);
      bus.a  = N'(av);
      bus.b  = N'(bv);
   endtask

   task automatic run_op(input string tag, input int opc, input int av, input int bv);
      int r;
      bit ovf;
      int lat;
      model(opc, av, bv, r, ovf);
      @(negedge clk_2);
      bus.start = 1'b1;
      drive(opc, av, bv);
      @(posedge clk_2); #1;
      bus.start = 1'b0;
      check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      lat = 0;
      wait_done(lat);
      check({tag, "_latency"}, lat, (opc == 5) ? N : 1);
      check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
      check_outputs(tag, r, ovf);
      @(posedge clk_2); #1;
      check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
   endtask

   initial begin
      int lat;
      bus.start = 1'b0;
      drive(0, 0, 0);
      #2 reset = 1'b1;
      #1;
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check_outputs("rst", 0, 1'b0);
      repeat (2) @(posedge clk_2);
      @(negedge clk_2) reset = 1'b0;

      run_op("add_7_1",  0, 7, 1);
      run_op("sub_m8_1", 1, -8, 1);
      run_op("and_5_m6", 2, 5, -6);
      run_op("mul_m8m8", 5, -8, -8);
      run_op("mul_3_m3", 5, 3, -3);

      // start during MUL is ignored and does not stretch busy
      @(negedge clk_2);
      bus.start = 1'b1;
      drive(5, 2, 3);
      @(posedge clk_2); #1;
      bus.start = 1'b0;
      @(negedge clk_2);
      bus.start = 1'b1;
      drive(0, 1, 1);
      @(posedge clk_2); #1;
      bus.start = 1'b0;
      lat = 1;
      wait_done(lat);
      check("mul_ign_latency", lat, N);
      check_outputs("mul_ign", 6, 1'b0);
      repeat (2) begin
         @(posedge clk_2); #1;
         check("mul_ign_idle", {30'b0, bus.busy, bus.done}, 32'd0);
      end

      // asynchronous reset mid-multiply
      @(negedge clk_2);
      bus.start = 1'b1;
      drive(5, -8, 3);
      @(posedge clk_2); #1;
      bus.start = 1'b0;
      @(posedge clk_2); #2;
      reset = 1'b1;
      #1;
      check("arst_busy", {31'b0, bus.busy}, 32'd0);
      check("arst_done", {31'b0, bus.done}, 32'd0);
      check_outputs("arst", 0, 1'b0);
      @(negedge clk_2) reset = 1'b0;
      repeat (N + 1) begin
         @(posedge clk_2); #1;
         check("arst_no_done", {30'b0, bus.busy, bus.done}, 32'd0);
      end
      run_op("neg_m8", 7, -8, 0);

      // back-to-back with start held high
      @(negedge clk_2);
      bus.start = 1'b1;
      drive(6, -1, 2);
      @(posedge clk_2); #1;
      drive(4, 6, 3);
      @(posedge clk_2); #1;
      check("b2b_done1", {31'b0, bus.done}, 32'd1);
      check_outputs("b2b_slt", 1, 1'b0);
      @(posedge clk_2); #1;
      bus.start = 1'b0;
      check("b2b_gap", {31'b0, bus.done}, 32'd0);
      @(posedge clk_2); #1;
      check("b2b_done2", {31'b0, bus.done}, 32'd1);
      check_outputs("b2b_xor", 5, 1'b0);

      for (int i = 0; i < 80; i++) begin
         run_op("rand", int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
